moving_sum_accum: RTL and testbench

//  Running-window accumulator sitting directly downstream of the sample delay line.

---
 rtl/moving_sum_accum.sv | 134 +++++++++++++
 tb/tb_moving_sum_accum.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/moving_sum_accum.sv
// -----------------------------------------------------------------------------
// moving_sum_accum
//
// Running-window accumulator placed after the sample delay line. Each input
// beat carries a pair {x_new, x_old}, where x_old is the same stream delayed by
// the window length. The block keeps S[n] = S[n-1] + x_new - x_old, which is
// the moving sum over the last len samples.
//
// Two-stage AXI-stream pipeline:
//   stage 1 (diff)       : d1 = x_new - x_old, WIDTH+1 bits, exact
//   stage 2 (accumulate) : acc = acc + sext(d1), wraps modulo 2^(WIDTH+MAX_LEN_LOG2)
//
// Ports:
//   clk       clock
//   reset     asynchronous, active-high reset
//   clear     synchronous clear: empties the pipeline and zeroes the sum
//   i_tdata   {x_new[2W-1:W], x_old[W-1:0]}, both signed
//   i_tlast   end of packet, carried alongside the data
//   i_tvalid  input valid
//   i_tready  input ready (combinational from o_tready through the ready terms)
//   o_tdata   signed moving sum S[n], WIDTH+MAX_LEN_LOG2 bits
//   o_tlast   tlast of the sample that produced S[n]
//   o_tvalid  output valid
//   o_tready  output ready
// -----------------------------------------------------------------------------
module moving_sum_accum #(
  parameter int WIDTH        = 16,
  parameter int MAX_LEN_LOG2 = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic [2*WIDTH-1:0]            i_tdata,
  input  logic                          i_tlast,
  input  logic                          i_tvalid,
  output logic                          i_tready,
  output logic [WIDTH+MAX_LEN_LOG2-1:0] o_tdata,
  output logic                          o_tlast,
  output logic                          o_tvalid,
  input  logic                          o_tready
);

  localparam int AW = WIDTH + MAX_LEN_LOG2;

  // Stage 1 registers
  logic signed [WIDTH:0]  d1_q, d1_d;
  logic                   t1_q, t1_d;
  logic                   v1_q, v1_d;

  // Stage 2 registers; the accumulator doubles as the output data register
  logic signed [AW-1:0]   acc_q, acc_d;
  logic                   o_tlast_q, o_tlast_d;
  logic                   o_tvalid_q, o_tvalid_d;

  logic signed [WIDTH-1:0] x_new;
  logic signed [WIDTH-1:0] x_old;
  logic                    s2_ready;
  logic                    s1_load;
  logic                    s2_load;

  assign x_new = i_tdata[2*WIDTH-1:WIDTH];
  assign x_old = i_tdata[WIDTH-1:0];

  // Ready chain: stage 2 can take a value when its output slot is empty or
  // being drained this cycle; stage 1 likewise relative to stage 2.
  assign s2_ready = ~o_tvalid_q | o_tready;
  assign i_tready = ~v1_q | s2_ready;
  assign s1_load  = i_tvalid & i_tready;
  assign s2_load  = v1_q & s2_ready;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    d1_d       = d1_q;
    t1_d       = t1_q;
    v1_d       = v1_q;
    acc_d      = acc_q;
    o_tlast_d  = o_tlast_q;
    o_tvalid_d = o_tvalid_q;

    if (clear) begin
      // Clear wins over both handshakes: any beat offered this cycle is dropped.
      v1_d       = 1'b0;
      acc_d      = '0;
      o_tlast_d  = 1'b0;
      o_tvalid_d = 1'b0;
    end else begin
      // Stage 1: the difference of two W-bit signed values needs W+1 bits.
      if (s1_load) begin
        d1_d = (WIDTH+1)'(x_new) - (WIDTH+1)'(x_old);
        t1_d = i_tlast;
        v1_d = 1'b1;
      end else if (s2_load) begin
        v1_d = 1'b0;
      end

      // Stage 2: a signed cast to AW bits sign-extends d1.
      if (s2_load) begin
        acc_d      = acc_q + AW'(d1_q);
        o_tlast_d  = t1_q;
        o_tvalid_d = 1'b1;
      end else if (o_tready) begin
        o_tvalid_d = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  // NOTE: the datapath registers are reset along with the control bits; it is
  // cheap here and keeps o_tdata/o_tlast at zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d1_q       <= '0;
      t1_q       <= 1'b0;
      v1_q       <= 1'b0;
      acc_q      <= '0;
      o_tlast_q  <= 1'b0;
      o_tvalid_q <= 1'b0;
    end else begin
      d1_q       <= d1_d;
      t1_q       <= t1_d;
      v1_q       <= v1_d;
      acc_q      <= acc_d;
      o_tlast_q  <= o_tlast_d;
      o_tvalid_q <= o_tvalid_d;
    end
  end

  assign o_tdata  = acc_q;
  assign o_tlast  = o_tlast_q;
  assign o_tvalid = o_tvalid_q;

endmodule

// File: tb/tb_moving_sum_accum.sv
// -----------------------------------------------------------------------------
// tb_moving_sum_accum
//
// Self-checking bench for moving_sum_accum. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. Expected sums come from
// plain arithmetic on the sample stream (window sums, closed forms, running
// totals) reduced modulo 2^(WIDTH+MAX_LEN_LOG2).
// -----------------------------------------------------------------------------
module tb_moving_sum_accum;

  localparam int WIDTH        = 16;
  localparam int MAX_LEN_LOG2 = 10;
  localparam int AW           = WIDTH + MAX_LEN_LOG2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 clear;
  logic [2*WIDTH-1:0]   i_tdata;
  logic                 i_tlast;
  logic                 i_tvalid;
  logic                 i_tready;
  logic [AW-1:0]        o_tdata;
  logic                 o_tlast;
  logic                 o_tvalid;
  logic                 o_tready;

  int checks   = 0;
  int failures = 0;

  // Stream under test and what came out of the DUT
  int            in_new[$];
  int            in_old[$];
  bit            in_last[$];
  logic [AW-1:0] got_data[$];
  bit            got_last[$];
  bit            timed_out;

  moving_sum_accum #(.WIDTH(WIDTH), .MAX_LEN_LOG2(MAX_LEN_LOG2)) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .i_tdata  (i_tdata),
    .i_tlast  (i_tlast),
    .i_tvalid (i_tvalid),
    .i_tready (i_tready),
    .o_tdata  (o_tdata),
    .o_tlast  (o_tlast),
    .o_tvalid (o_tvalid),
    .o_tready (o_tready)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] wrap(input longint v);
    logic [63:0] t;
    t = v;
    return t[AW-1:0];
  endfunction

  function automatic logic [2*WIDTH-1:0] pack(input int xn, input int xo);
    logic [31:0] a;
    logic [31:0] b;
    a = xn;
    b = xo;
    return {a[WIDTH-1:0], b[WIDTH-1:0]};
  endfunction

  function automatic int rand_sample();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic do_clear();
    @(posedge clk); #1;
    i_tvalid = 1'b0;
    clear    = 1'b1;
    @(posedge clk); #1;
    clear    = 1'b0;
  endtask

  // Streams in_* through the DUT. mode 0: o_tready held high; mode 1: random.
  // gap_pct: chance of an idle cycle before each new input beat.
  task automatic run_stream(input int mode, input int gap_pct);
    int idx;
    bit accepted;
    idx       = 0;
    accepted  = 1'b0;
    timed_out = 1'b1;
    got_data.delete();
    got_last.delete();
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk); #1;
      if (accepted) idx++;
      o_tready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (idx >= in_new.size()) begin
        i_tvalid = 1'b0;
      end else if (accepted || !i_tvalid) begin
        if (int'($urandom_range(0, 99)) < gap_pct) begin
          i_tvalid = 1'b0;
        end else begin
          i_tvalid = 1'b1;
          i_tdata  = pack(in_new[idx], in_old[idx]);
          i_tlast  = in_last[idx];
        end
      end
      @(negedge clk);
      accepted = i_tvalid && i_tready;
      if (o_tvalid && o_tready) begin
        got_data.push_back(o_tdata);
        got_last.push_back(o_tlast);
      end
      if (got_data.size() == in_new.size()) begin
        timed_out = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
    i_tvalid = 1'b0;
    o_tready = 1'b1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    clear    = 1'b0;
    i_tvalid = 1'b0;
    i_tdata  = '0;
    i_tlast  = 1'b0;
    o_tready = 1'b1;
    #12;
    checks++;
    if (o_tvalid !== 1'b0 || o_tdata !== '0 || o_tlast !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b data=%0d last=%b, want 0/0/0",
               o_tvalid, o_tdata, o_tlast);
    end
    checks++;
    if (i_tready !== 1'b1) begin
      failures++;
      $display("FAIL reset_tready: got %b want 1", i_tready);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // x_new = 1..8, x_old = 0, continuous beats: outputs are triangular numbers,
  // one per clock, first one two edges after the first beat is presented.
  task automatic test_ramp();
    longint expv;
    o_tready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (c < 8) begin
        i_tvalid = 1'b1;
        i_tdata  = pack(c + 1, 0);
        i_tlast  = 1'b0;
      end else begin
        i_tvalid = 1'b0;
      end
      @(negedge clk);
      if (c < 2) begin
        checks++;
        if (o_tvalid !== 1'b0) begin
          failures++;
          $display("FAIL ramp_latency c=%0d: o_tvalid=%b want 0", c, o_tvalid);
        end
      end else begin
        expv = longint'(c - 1) * longint'(c) / 2;
        checks++;
        if (o_tvalid !== 1'b1 || o_tdata !== wrap(expv)) begin
          failures++;
          $display("FAIL ramp_sum c=%0d: got valid=%b data=%0d want 1/%0d",
                   c, o_tvalid, $signed(o_tdata), expv);
        end
      end
    end
  endtask

  // Pairs built from a real delay of len: expected output is the plain sum of
  // the last len x_new values.
  task automatic test_window();
    int     len;
    int     n;
    longint expv;
    for (int cfg = 0; cfg < 2; cfg++) begin
      in_new.delete(); in_old.delete(); in_last.delete();
      len = (cfg == 0) ? 4 : int'($urandom_range(2, 8));
      n   = (cfg == 0) ? 10 : 40;
      for (int i = 0; i < n; i++) begin
        in_new.push_back((cfg == 0) ? 5 : rand_sample());
        in_old.push_back((i >= len) ? in_new[i - len] : 0);
        in_last.push_back(1'b0);
      end
      do_clear();
      run_stream(cfg, (cfg == 0) ? 0 : 20);
      checks++;
      if (timed_out || got_data.size() != n) begin
        failures++;
        $display("FAIL window_count cfg=%0d: got %0d outputs want %0d", cfg, got_data.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          expv = 0;
          for (int j = ((i - len + 1) > 0 ? (i - len + 1) : 0); j <= i; j++) expv += in_new[j];
          checks++;
          if (got_data[i] !== wrap(expv)) begin
            failures++;
            $display("FAIL window_sum cfg=%0d len=%0d i=%0d: got %0d want %0d",
                     cfg, len, i, $signed(got_data[i]), expv);
          end
        end
      end
    end
  endtask

  // Full-scale negative difference every beat. After 500 beats the sum is
  // still representable; after 1000 it has wrapped modulo 2^AW.
  task automatic test_extremes();
    in_new.delete(); in_old.delete(); in_last.delete();
    for (int i = 0; i < 1000; i++) begin
      in_new.push_back(-32768);
      in_old.push_back(32767);
      in_last.push_back(1'b0);
    end
    do_clear();
    run_stream(0, 0);
    checks++;
    if (timed_out || got_data.size() != 1000) begin
      failures++;
      $display("FAIL extremes_count: got %0d outputs want 1000", got_data.size());
    end else begin
      checks++;
      if (got_data[499] !== wrap(-64'sd32767500)) begin
        failures++;
        $display("FAIL extremes_exact: got %0d want -32767500", $signed(got_data[499]));
      end
      checks++;
      if (got_data[999] !== wrap(-64'sd65535000)) begin
        failures++;
        $display("FAIL extremes_wrap: got %0d want %0d", $signed(got_data[999]),
                 $signed(wrap(-64'sd65535000)));
      end
      for (int i = 0; i < 1000; i++) begin
        checks++;
        if (got_data[i] !== wrap(longint'(i + 1) * -64'sd65535)) begin
          failures++;
          $display("FAIL extremes_seq i=%0d: got %0d want %0d", i, $signed(got_data[i]),
                   longint'(i + 1) * -64'sd65535);
        end
      end
    end
  endtask

  // o_tready low for 5 clocks with the pipeline full: output held, input
  // stalled, and the full stream still comes out exactly once and in order.
  task automatic test_backpressure();
    int            idx;
    bit            accepted;
    logic [AW-1:0] held_d;
    bit            held_l;
    longint        s;
    int            n;
    n = 12;
    in_new.delete(); in_old.delete(); in_last.delete();
    for (int i = 0; i < n; i++) begin
      in_new.push_back(rand_sample());
      in_old.push_back(rand_sample());
      in_last.push_back(1'($urandom_range(0, 1)));
    end
    do_clear();
    got_data.delete(); got_last.delete();
    idx      = 0;
    accepted = 1'b0;
    held_d   = '0;
    held_l   = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (accepted) idx++;
      o_tready = (c >= 4 && c <= 8) ? 1'b0 : 1'b1;
      if (idx < n) begin
        i_tvalid = 1'b1;
        i_tdata  = pack(in_new[idx], in_old[idx]);
        i_tlast  = in_last[idx];
      end else begin
        i_tvalid = 1'b0;
      end
      @(negedge clk);
      accepted = i_tvalid && i_tready;
      if (o_tvalid && o_tready) begin
        got_data.push_back(o_tdata);
        got_last.push_back(o_tlast);
      end
      if (c == 4) begin
        held_d = o_tdata;
        held_l = o_tlast;
        checks++;
        if (o_tvalid !== 1'b1) begin
          failures++;
          $display("FAIL bp_full: o_tvalid=%b want 1 at stall start", o_tvalid);
        end
      end
      if (c >= 4 && c <= 8) begin
        checks++;
        if (i_tready !== 1'b0) begin
          failures++;
          $display("FAIL bp_tready c=%0d: i_tready=%b want 0", c, i_tready);
        end
      end
      if (c >= 5 && c <= 8) begin
        checks++;
        if (o_tvalid !== 1'b1 || o_tdata !== held_d || o_tlast !== held_l) begin
          failures++;
          $display("FAIL bp_stable c=%0d: got %b/%0d/%b want 1/%0d/%b", c, o_tvalid,
                   $signed(o_tdata), o_tlast, $signed(held_d), held_l);
        end
      end
    end
    i_tvalid = 1'b0;
    o_tready = 1'b1;
    checks++;
    if (got_data.size() != n) begin
      failures++;
      $display("FAIL bp_count: got %0d outputs want %0d", got_data.size(), n);
    end else begin
      s = 0;
      for (int i = 0; i < n; i++) begin
        s += longint'(in_new[i]) - longint'(in_old[i]);
        checks++;
        if (got_data[i] !== wrap(s) || got_last[i] !== in_last[i]) begin
          failures++;
          $display("FAIL bp_data i=%0d: got %0d/%b want %0d/%b", i, $signed(got_data[i]),
                   got_last[i], s, in_last[i]);
        end
      end
    end
  endtask

  // tlast on the 3rd of 6 beats: only the 3rd output carries it, and the sum
  // keeps running across the packet boundary.
  task automatic test_tlast();
    longint s;
    in_new.delete(); in_old.delete(); in_last.delete();
    for (int i = 0; i < 6; i++) begin
      in_new.push_back(rand_sample());
      in_old.push_back(rand_sample());
      in_last.push_back(i == 2);
    end
    do_clear();
    run_stream(1, 30);
    checks++;
    if (timed_out || got_data.size() != 6) begin
      failures++;
      $display("FAIL tlast_count: got %0d outputs want 6", got_data.size());
    end else begin
      s = 0;
      for (int i = 0; i < 6; i++) begin
        s += longint'(in_new[i]) - longint'(in_old[i]);
        checks++;
        if (got_last[i] !== (i == 2) || got_data[i] !== wrap(s)) begin
          failures++;
          $display("FAIL tlast_beat i=%0d: got %b/%0d want %b/%0d", i, got_last[i],
                   $signed(got_data[i]), (i == 2), s);
        end
      end
    end
  endtask

  // clear with acc=100 and a second beat sitting in stage 1: both that beat
  // and the one offered alongside clear are lost; the next output is just the
  // next beat's difference.
  task automatic test_clear();
    do_clear();
    o_tready = 1'b1;
    @(posedge clk); #1;
    i_tvalid = 1'b1; i_tdata = pack(100, 0); i_tlast = 1'b1;
    @(posedge clk); #1;
    i_tdata = pack(7, 3); i_tlast = 1'b0;
    @(posedge clk); #1;
    i_tdata = pack(50, 20);
    clear   = 1'b1;
    @(negedge clk);
    checks++;
    if (o_tvalid !== 1'b1 || o_tdata !== wrap(100) || i_tready !== 1'b1) begin
      failures++;
      $display("FAIL clear_pre: got valid=%b data=%0d tready=%b want 1/100/1",
               o_tvalid, $signed(o_tdata), i_tready);
    end
    @(posedge clk); #1;
    clear    = 1'b0;
    i_tvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_tvalid !== 1'b0 || o_tdata !== '0 || o_tlast !== 1'b0) begin
      failures++;
      $display("FAIL clear_zero: got %b/%0d/%b want 0/0/0", o_tvalid, $signed(o_tdata), o_tlast);
    end
    @(posedge clk); #1;
    i_tvalid = 1'b1; i_tdata = pack(9, 2);
    @(negedge clk);
    checks++;
    if (o_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL clear_drain1: o_tvalid=%b want 0", o_tvalid);
    end
    @(posedge clk); #1;
    i_tvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL clear_drain2: o_tvalid=%b want 0", o_tvalid);
    end
    @(negedge clk);
    checks++;
    if (o_tvalid !== 1'b1 || o_tdata !== wrap(7)) begin
      failures++;
      $display("FAIL clear_next: got %b/%0d want 1/7", o_tvalid, $signed(o_tdata));
    end
  endtask

  // Async reset while the output is stalled: outputs drop without waiting for
  // an edge, and the next beat starts from zero.
  task automatic test_async_reset();
    do_clear();
    o_tready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      i_tvalid = 1'b1; i_tdata = pack(10, 0); i_tlast = 1'b1;
    end
    @(posedge clk); #1;
    i_tvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_tvalid !== 1'b1 || o_tdata !== wrap(10)) begin
      failures++;
      $display("FAIL areset_pre: got %b/%0d want 1/10", o_tvalid, $signed(o_tdata));
    end
    reset = 1'b1;
    #1;
    checks++;
    if (o_tvalid !== 1'b0 || o_tdata !== '0 || o_tlast !== 1'b0 || i_tready !== 1'b1) begin
      failures++;
      $display("FAIL areset_now: got %b/%0d/%b tready=%b want 0/0/0 tready=1",
               o_tvalid, $signed(o_tdata), o_tlast, i_tready);
    end
    @(negedge clk);
    reset    = 1'b0;
    o_tready = 1'b1;
    @(posedge clk); #1;
    i_tvalid = 1'b1; i_tdata = pack(3, 1); i_tlast = 1'b0;
    @(posedge clk); #1;
    i_tvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL areset_lat: o_tvalid=%b want 0", o_tvalid);
    end
    @(negedge clk);
    checks++;
    if (o_tvalid !== 1'b1 || o_tdata !== wrap(2)) begin
      failures++;
      $display("FAIL areset_first: got %b/%0d want 1/2", o_tvalid, $signed(o_tdata));
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_window();
    test_extremes();
    test_backpressure();
    test_tlast();
    test_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
